// File: rtl/mmio_timer_responder_pkg.sv
// Shared register map, CTRL bit layout and default constants for the MMIO timer,
// imported by both the RTL and the bench.
package mmio_timer_responder_pkg;

  localparam logic [31:0] BASE_DEFAULT = 32'hFFFF_FF00;
  localparam logic [31:0] ID_DEFAULT   = 32'h5449_4D31;

  localparam logic [5:0] OFF_CTRL    = 6'd0;
  localparam logic [5:0] OFF_COUNT   = 6'd1;
  localparam logic [5:0] OFF_COMPARE = 6'd2;
  localparam logic [5:0] OFF_STATUS  = 6'd3;
  localparam logic [5:0] OFF_ID      = 6'd4;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_W          = 3;

endpackage

// File: rtl/timer_core.sv
// Counter, compare and sticky MATCH flag; the top decodes the bus into
// per-register write strobes and this block owns all timer state.
module timer_core
  import mmio_timer_responder_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_we,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic              status_we,
  input  logic [31:0]       wdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [31:0]       count,
  output logic [31:0]       compare,
  output logic              match
);

  logic en;
  logic hit_cmp;

  assign en      = ctrl[CTRL_EN];
  assign hit_cmp = en && (count == compare);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= '0;
      match   <= 1'b0;
    end else begin
      if (ctrl_we)    ctrl    <= wdata[CTRL_W-1:0];
      if (compare_we) compare <= wdata;

      // A CPU write beats both the reload and the increment.
      if (count_we)                              count <= wdata;
      else if (hit_cmp && ctrl[CTRL_AUTORELOAD]) count <= '0;
      else if (en)                               count <= count + 32'd1;

      // A new match beats a simultaneous write-1-to-clear.
      if (hit_cmp)                    match <= 1'b1;
      else if (status_we && wdata[0]) match <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped timer slave: decodes a 256-byte window, registers read data and
// Hit one cycle after the access, and drives Irq from register state only.
module mmio_timer_responder
  import mmio_timer_responder_pkg::*;
#(
  parameter logic [31:0] BASE     = BASE_DEFAULT,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemWriteRead,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Irq
);

  logic              in_window;
  logic [5:0]        offset;
  logic              wr;
  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       count;
  logic [31:0]       compare;
  logic              match;
  logic [31:0]       rd_next;
  logic              unused_addr_lsbs;

  assign in_window        = (Address[31:8] == BASE[31:8]);
  assign offset           = Address[7:2];
  assign wr               = in_window && MemWriteRead;
  assign unused_addr_lsbs = ^Address[1:0];

  timer_core u_core (
    .clock      (clock),
    .reset      (reset),
    .ctrl_we    (wr && (offset == OFF_CTRL)),
    .count_we   (wr && (offset == OFF_COUNT)),
    .compare_we (wr && (offset == OFF_COMPARE)),
    .status_we  (wr && (offset == OFF_STATUS)),
    .wdata      (WriteData),
    .ctrl       (ctrl),
    .count      (count),
    .compare    (compare),
    .match      (match)
  );

  always_comb begin
    rd_next = '0;
    if (in_window && !MemWriteRead) begin
      case (offset)
        OFF_CTRL:    rd_next = {{(32-CTRL_W){1'b0}}, ctrl};
        OFF_COUNT:   rd_next = count;
        OFF_COMPARE: rd_next = compare;
        OFF_STATUS:  rd_next = {31'd0, match};
        OFF_ID:      rd_next = ID_VALUE;
        default:     rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ReadData <= '0;
      Hit      <= 1'b0;
    end else begin
      ReadData <= rd_next;
      Hit      <= in_window;
    end
  end

  assign Irq = match && ctrl[CTRL_IRQEN];

endmodule
